// File: rtl/frog_motion_ctrl.sv
// Frog position/lives controller: debounced buttons queue one hop, applied on frame_tick.
// Optional FROG_WRAP_X_EN macro: horizontal hops off either edge wrap to the other side.
module frog_motion_ctrl #(
   parameter int START_X         = 316,
   parameter int START_Y         = 464,
   parameter int STEP            = 8,
   parameter int MAX_X           = 632,
   parameter int MAX_Y           = 472,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int COOLDOWN_FRAMES = 4,
   parameter int DEATH_FRAMES    = 30,
   parameter int LIVES           = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       frame_tick_i,
   input  logic       hit_i,
   input  logic       restart_i,
   output logic [9:0] frog_x_o,
   output logic [9:0] frog_y_o,
   output logic       frog_alive_o,
   output logic [1:0] lives_o,
   output logic       goal_pulse_o,
   output logic       game_over_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PENDING   = 3'd1;
   localparam logic [2:0] S_COOLDOWN  = 3'd2;
   localparam logic [2:0] S_DEAD      = 3'd3;
   localparam logic [2:0] S_GOAL      = 3'd4;
   localparam logic [2:0] S_GAME_OVER = 3'd5;

   localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FMAX   = (DEATH_FRAMES > COOLDOWN_FRAMES) ? DEATH_FRAMES : COOLDOWN_FRAMES;
   localparam int FCW    = $clog2(FMAX + 1);

   // Button bit order: 0 up, 1 down, 2 left, 3 right (also the priority order).
   logic [3:0]     btn_raw;
   logic [3:0]     sync1_q, sync2_q, db_q, db_prev_q;
   logic [DBW-1:0] db_cnt_q [4];
   logic [3:0]     press;
   logic           press_any;
   logic [1:0]     dir_sel;

   assign btn_raw = {btn_right_i, btn_left_i, btn_down_i, btn_up_i};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               db_q[i]     <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press     = db_q & ~db_prev_q;
   assign press_any = |press;

   always_comb begin
      dir_sel = 2'd3;
      if (press[0])      dir_sel = 2'd0;
      else if (press[1]) dir_sel = 2'd1;
      else if (press[2]) dir_sel = 2'd2;
   end

   logic [2:0]     state_q, state_d;
   logic [1:0]     dir_q, dir_d;
   logic [9:0]     x_q, x_d, y_q, y_d;
   logic [1:0]     lives_q, lives_d;
   logic           alive_q, alive_d;
   logic           goal_q, goal_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;

   logic [9:0] tx, ty;
   logic       legal;

   always_comb begin
      tx    = x_q;
      ty    = y_q;
      legal = 1'b1;
      case (dir_q)
         2'd0: begin
            if (y_q < 10'(STEP)) legal = 1'b0;
            else                 ty    = y_q - 10'(STEP);
         end
         2'd1: begin
            if (y_q > 10'(MAX_Y - STEP)) legal = 1'b0;
            else                         ty    = y_q + 10'(STEP);
         end
         2'd2: begin
            if (x_q >= 10'(STEP)) begin
               tx = x_q - 10'(STEP);
            end else begin
`ifdef FROG_WRAP_X_EN
               tx = 10'(MAX_X);
`else
               legal = 1'b0;
`endif
            end
         end
         default: begin
            if (x_q <= 10'(MAX_X - STEP)) begin
               tx = x_q + 10'(STEP);
            end else begin
`ifdef FROG_WRAP_X_EN
               tx = 10'd0;
`else
               legal = 1'b0;
`endif
            end
         end
      endcase
   end

   logic active;
   assign active = (state_q == S_IDLE) || (state_q == S_PENDING) || (state_q == S_COOLDOWN);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      x_d     = x_q;
      y_d     = y_q;
      lives_d = lives_q;
      alive_d = alive_q;
      goal_d  = 1'b0;
      fcnt_d  = fcnt_q;
      // A hit pre-empts any hop or frame tick arriving in the same cycle.
      if (active && hit_i) begin
         lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
         alive_d = 1'b0;
         if (lives_q <= 2'd1) begin
            state_d = S_GAME_OVER;
         end else begin
            state_d = S_DEAD;
            fcnt_d  = FCW'(DEATH_FRAMES);
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (press_any) begin
                  state_d = S_PENDING;
                  dir_d   = dir_sel;
               end
            end
            S_PENDING: begin
               if (frame_tick_i) begin
                  if (legal) begin
                     x_d = tx;
                     y_d = ty;
                     if (ty == 10'd0) begin
                        goal_d  = 1'b1;
                        state_d = S_GOAL;
                     end else begin
                        state_d = S_COOLDOWN;
                        fcnt_d  = FCW'(COOLDOWN_FRAMES);
                     end
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_COOLDOWN: begin
               if (frame_tick_i) begin
                  if (fcnt_q <= FCW'(1)) begin
                     fcnt_d  = '0;
                     state_d = S_IDLE;
                  end else begin
                     fcnt_d = fcnt_q - 1'b1;
                  end
               end
            end
            S_DEAD: begin
               if (frame_tick_i) begin
                  if (fcnt_q <= FCW'(1)) begin
                     fcnt_d  = '0;
                     x_d     = 10'(START_X);
                     y_d     = 10'(START_Y);
                     alive_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     fcnt_d = fcnt_q - 1'b1;
                  end
               end
            end
            S_GOAL: begin
               if (frame_tick_i) begin
                  x_d     = 10'(START_X);
                  y_d     = 10'(START_Y);
                  state_d = S_IDLE;
               end
            end
            S_GAME_OVER: begin
               if (restart_i) begin
                  lives_d = 2'(LIVES);
                  x_d     = 10'(START_X);
                  y_d     = 10'(START_Y);
                  alive_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         dir_q   <= 2'd0;
         x_q     <= 10'(START_X);
         y_q     <= 10'(START_Y);
         lives_q <= 2'(LIVES);
         alive_q <= 1'b1;
         goal_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lives_q <= lives_d;
         alive_q <= alive_d;
         goal_q  <= goal_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign frog_x_o     = x_q;
   assign frog_y_o     = y_q;
   assign frog_alive_o = alive_q;
   assign lives_o      = lives_q;
   assign goal_pulse_o = goal_q;
   assign game_over_o  = (state_q == S_GAME_OVER);
   assign state_o      = state_q;

endmodule
